// File: rtl/tow_pkg.sv
// Shared encodings for the Tug of War game: LED mux select codes, marker
// positions and round controller states. Also used by the LED mux.
package tow_pkg;

  typedef enum logic [1:0] {
    LEDS_ALL_OFF    = 2'd0,
    LEDS_ALL_ON     = 2'd1,
    LEDS_RESET_CODE = 2'd2,
    LEDS_SCORE      = 2'd3
  } leds_code_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_DARK  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  localparam logic [6:0] SCORE_CENTER    = 7'b0001000;
  localparam logic [6:0] SCORE_LEFT_END  = 7'b1000000;
  localparam logic [6:0] SCORE_RIGHT_END = 7'b0000001;

  // True when the marker sits on either end LED, i.e. the game is decided.
  function automatic logic is_end(input logic [6:0] s);
    return (s == SCORE_LEFT_END) || (s == SCORE_RIGHT_END);
  endfunction

endpackage

// File: rtl/tow_edge_det.sv
// Rising-edge detector for a debounced, synchronised button. History resets
// to 1 so a button held through reset never looks like a fresh press.
module tow_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic rise
);

  logic pb_q;

  always_ff @(posedge clk) begin
    if (rst) pb_q <= 1'b1;
    else     pb_q <= pb;
  end

  assign rise = pb & ~pb_q;

endmodule

// File: rtl/tow_round_ctrl.sv
// Tug of War round controller: reset hold, dark period, marker show and win
// blink, with foul handling. All outputs are registered.
module tow_round_ctrl
  import tow_pkg::*;
#(
  parameter int RESET_HOLD   = 25000000,
  parameter int DARK_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 12500000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic [1:0] leds_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner
);

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] DARK_LAST  = CNT_W'(DARK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [6:0]       score_next;
  logic             blink, blink_next;
  leds_code_t       leds_next;
  logic [1:0]       winner_next;
  logic             lp, rp;

  tow_edge_det u_edge_l (.clk(clk), .rst(rst), .pb(pbl), .rise(lp));
  tow_edge_det u_edge_r (.clk(clk), .rst(rst), .pb(pbr), .rise(rp));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RESET;
      timer     <= '0;
      score     <= SCORE_CENTER;
      blink     <= 1'b1;
      leds_ctrl <= LEDS_RESET_CODE;
      winner    <= 2'b00;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      score     <= score_next;
      blink     <= blink_next;
      leds_ctrl <= leds_next;
      winner    <= winner_next;
    end
  end

  // A press in DARK is a foul: the marker moves toward the other player.
  always_comb begin
    state_next = state;
    timer_next = timer + 1'b1;
    score_next = score;
    blink_next = blink;
    unique case (state)
      ST_RESET: begin
        if (timer == RESET_LAST) begin
          state_next = ST_DARK;
          timer_next = '0;
        end
      end
      ST_DARK: begin
        if (lp || rp) begin
          timer_next = '0;
          if (lp && !rp)      score_next = score >> 1;
          else if (rp && !lp) score_next = score << 1;
          if (is_end(score_next)) begin
            state_next = ST_WIN;
            blink_next = 1'b1;
          end
        end else if (timer == DARK_LAST) begin
          state_next = ST_SHOW;
          timer_next = '0;
        end
      end
      ST_SHOW: begin
        timer_next = '0;
        if (lp || rp) begin
          if (lp && !rp)      score_next = score << 1;
          else if (rp && !lp) score_next = score >> 1;
          state_next = is_end(score_next) ? ST_WIN : ST_DARK;
          blink_next = 1'b1;
        end
      end
      ST_WIN: begin
        if (timer == BLINK_LAST) begin
          timer_next = '0;
          blink_next = ~blink;
        end
      end
      default: begin
        state_next = ST_RESET;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so the registers show them
  // on the same edge the state changes.
  always_comb begin
    leds_next   = LEDS_ALL_OFF;
    winner_next = 2'b00;
    unique case (state_next)
      ST_RESET: leds_next = LEDS_RESET_CODE;
      ST_DARK:  leds_next = LEDS_ALL_OFF;
      ST_SHOW:  leds_next = LEDS_SCORE;
      ST_WIN: begin
        leds_next   = blink_next ? LEDS_SCORE : LEDS_ALL_ON;
        winner_next = {score_next[6], score_next[0]};
      end
      default:  leds_next = LEDS_ALL_OFF;
    endcase
  end

endmodule
